burst_accumulator: RTL and testbench

//  Sequential accumulate stage that consumes the 32-bit CarryByPassAdder. Accepts signed

---
 rtl/burst_accumulator.sv | 160 ++++++++++++++++
 tb/tb_burst_accumulator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/burst_accumulator.sv
// Burst accumulator: adds/subtracts BURST_LEN signed operands into a running sum via a
// 32-bit carry-bypass adder. Optional macro SATURATE_EN clamps the sum on overflow.
module CarryByPassAdder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout,
    output logic        posOverflow,
    output logic        negOverflow
);
    logic [31:0] w_p;
    logic [31:0] w_g;
    logic [7:0]  w_blk_p;
    logic [32:0] w_c;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_blk
            assign w_p[gi*4 +: 4] = a[gi*4 +: 4] ^ b[gi*4 +: 4];
            assign w_g[gi*4 +: 4] = a[gi*4 +: 4] & b[gi*4 +: 4];
            assign w_blk_p[gi]    = &w_p[gi*4 +: 4];
        end
    endgenerate

    // Ripple inside each 4-bit block; a fully propagating block forwards its carry-in.
    always_comb begin
        w_c = '0;
        w_c[0] = Cin;
        for (int blk = 0; blk < 8; blk++) begin
            for (int bit_i = 0; bit_i < 4; bit_i++) begin
                w_c[blk*4 + bit_i + 1] = w_g[blk*4 + bit_i] | (w_p[blk*4 + bit_i] & w_c[blk*4 + bit_i]);
            end
            if (w_blk_p[blk]) begin
                w_c[blk*4 + 4] = w_c[blk*4];
            end
        end
    end

    assign S           = w_p ^ w_c[31:0];
    assign Cout        = w_c[32];
    assign posOverflow = ~a[31] & ~b[31] &  S[31];
    assign negOverflow =  a[31] &  b[31] & ~S[31];
endmodule

module burst_accumulator #(
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_pos_ovf,
    output logic        out_neg_ovf,
    output logic        out_cout
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_acc;
    logic [7:0]  r_cnt;
    logic        r_pos_ovf;
    logic        r_neg_ovf;
    logic        r_cout;
    logic        r_in_ready;
    logic        r_out_valid;

    logic [31:0] w_b;
    logic [31:0] w_s;
    logic        w_cout;
    logic        w_pos;
    logic        w_neg;
    logic [31:0] w_acc_next;

    assign w_b = in_sub ? ~in_data : in_data;

    CarryByPassAdder u_adder (
        .a           (r_acc),
        .b           (w_b),
        .Cin         (in_sub),
        .S           (w_s),
        .Cout        (w_cout),
        .posOverflow (w_pos),
        .negOverflow (w_neg)
    );

`ifdef SATURATE_EN
    assign w_acc_next = w_pos ? 32'h7FFF_FFFF : (w_neg ? 32'h8000_0000 : w_s);
`else
    assign w_acc_next = w_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pos_ovf   <= 1'b0;
            r_neg_ovf   <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pos_ovf   <= 1'b0;
            r_neg_ovf   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid && r_in_ready) begin
                        r_acc     <= w_acc_next;
                        r_pos_ovf <= r_pos_ovf | w_pos;
                        r_neg_ovf <= r_neg_ovf | w_neg;
                        r_cout    <= w_cout;
                        if (r_cnt == 8'(BURST_LEN - 1)) begin
                            r_cnt       <= '0;
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    // Release cycle: nothing accepted until ACCUM is re-entered.
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_pos_ovf   <= 1'b0;
                        r_neg_ovf   <= 1'b0;
                        r_state     <= ACCUM;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_sum     = r_acc;
    assign out_pos_ovf = r_pos_ovf;
    assign out_neg_ovf = r_neg_ovf;
    assign out_cout    = r_cout;
endmodule

// File: tb/tb_burst_accumulator.sv
// Directed testbench for burst_accumulator (BURST_LEN=4); expectations follow SATURATE_EN.
module tb_burst_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_pos_ovf;
    logic        out_neg_ovf;
    logic        out_cout;

    int check_cnt = 0;
    int pass_cnt  = 0;

    burst_accumulator #(.BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_pos_ovf(out_pos_ovf), .out_neg_ovf(out_neg_ovf),
        .out_cout(out_cout)
    );

    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic push(input logic [31:0] d, input logic s);
        in_data = d; in_sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sub = 1'b0;
        $display("push data=%h sub=%0d -> out_valid=%0d out_sum=%h", d, s, out_valid, out_sum);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("release -> out_valid=%0d out_sum=%h", out_valid, out_sum);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        check_cnt++; if (out_sum !== 32'h0) $display("FAIL reset_out_sum got %h exp 0", out_sum); else pass_cnt++;
        check_cnt++; if ({out_pos_ovf, out_neg_ovf, out_cout} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {out_pos_ovf, out_neg_ovf, out_cout}); else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        push(32'd8, 1'b0); push(32'd7, 1'b0); push(-32'sd3, 1'b0);
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", out_valid); else pass_cnt++;
        push(32'd2, 1'b0);
        check_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", out_valid); else pass_cnt++;
        check_cnt++; if (out_sum !== 32'd14) $display("FAIL basic_sum got %h exp %h", out_sum, 32'd14); else pass_cnt++;
        check_cnt++; if ({out_pos_ovf, out_neg_ovf} !== 2'b00) $display("FAIL basic_flags got %b exp 00", {out_pos_ovf, out_neg_ovf}); else pass_cnt++;
        check_cnt++; if (out_cout !== 1'b0) $display("FAIL basic_cout got %b exp 0", out_cout); else pass_cnt++;
        release_result();
        check_cnt++; if (out_valid !== 1'b0 || out_sum !== 32'h0) $display("FAIL basic_release got v=%b sum=%h exp v=0 sum=0", out_valid, out_sum); else pass_cnt++;
    endtask

    task automatic test_pos_ovf();
        logic [31:0] exp_sum;
`ifdef SATURATE_EN
        exp_sum = 32'h7FFF_FFFF;
`else
        exp_sum = 32'h8000_0000;
`endif
        push(32'h7FFF_FFFF, 1'b0); push(32'd1, 1'b0); push(32'd0, 1'b0); push(32'd0, 1'b0);
        check_cnt++; if ({out_pos_ovf, out_neg_ovf} !== 2'b10) $display("FAIL posovf_flags got %b exp 10", {out_pos_ovf, out_neg_ovf}); else pass_cnt++;
        check_cnt++; if (out_sum !== exp_sum) $display("FAIL posovf_sum got %h exp %h", out_sum, exp_sum); else pass_cnt++;
        release_result();
        check_cnt++; if ({out_pos_ovf, out_neg_ovf} !== 2'b00) $display("FAIL posovf_flag_clear got %b exp 00", {out_pos_ovf, out_neg_ovf}); else pass_cnt++;
    endtask

    task automatic test_sub_ovf();
        logic [31:0] exp_sum;
`ifdef SATURATE_EN
        exp_sum = 32'h7FFF_FFFF;
`else
        exp_sum = 32'h8000_0000;
`endif
        push(32'h8000_0000, 1'b1); push(32'd0, 1'b0); push(32'd0, 1'b0); push(32'd0, 1'b0);
        check_cnt++; if ({out_pos_ovf, out_neg_ovf} !== 2'b10) $display("FAIL subovf_flags got %b exp 10", {out_pos_ovf, out_neg_ovf}); else pass_cnt++;
        check_cnt++; if (out_sum !== exp_sum) $display("FAIL subovf_sum got %h exp %h", out_sum, exp_sum); else pass_cnt++;
        release_result();
    endtask

    task automatic test_both_flags();
        // Wrap path: 8000_0000 (pos) -> 0 (neg) -> 8000_0000. Saturate path ends at 8000_0000 too.
        push(32'h7FFF_FFFF, 1'b0); push(32'd1, 1'b0); push(32'h8000_0000, 1'b0); push(32'h8000_0000, 1'b0);
        check_cnt++; if ({out_pos_ovf, out_neg_ovf} !== 2'b11) $display("FAIL both_flags got %b exp 11", {out_pos_ovf, out_neg_ovf}); else pass_cnt++;
        check_cnt++; if (out_sum !== 32'h8000_0000) $display("FAIL both_sum got %h exp 80000000", out_sum); else pass_cnt++;
        release_result();
    endtask

    task automatic test_cout();
        push(32'd1, 1'b0); push(32'd2, 1'b0); push(32'd3, 1'b0); push(32'hFFFF_FFFF, 1'b0);
        check_cnt++; if (out_cout !== 1'b1) $display("FAIL cout_last got %b exp 1", out_cout); else pass_cnt++;
        check_cnt++; if (out_sum !== 32'd5) $display("FAIL cout_sum got %h exp 5", out_sum); else pass_cnt++;
        release_result();
    endtask

    task automatic test_hold_stall();
        int bad;
        push(32'd1, 1'b0); push(32'd1, 1'b0); push(32'd1, 1'b0); push(32'd1, 1'b0);
        in_data = 32'd99; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            $display("stall cycle %0d in_ready=%0d out_valid=%0d out_sum=%h", i, in_ready, out_valid, out_sum);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 32'd4) bad++;
        end
        check_cnt++; if (bad != 0) $display("FAIL hold_stable got %0d bad cycles exp 0", bad); else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_cnt++; if (out_sum !== 32'd0 || in_ready !== 1'b1) $display("FAIL hold_release got sum=%h rdy=%b exp sum=0 rdy=1", out_sum, in_ready); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_cnt++; if (out_sum !== 32'd99) $display("FAIL hold_first_accept got %h exp %h", out_sum, 32'd99); else pass_cnt++;
        push(32'd0, 1'b0); push(32'd0, 1'b0);
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL hold_count_early got %b exp 0", out_valid); else pass_cnt++;
        push(32'd0, 1'b0);
        check_cnt++; if (out_valid !== 1'b1 || out_sum !== 32'd99) $display("FAIL hold_burst2 got v=%b sum=%h exp v=1 sum=63", out_valid, out_sum); else pass_cnt++;
        release_result();
    endtask

    task automatic test_clear();
        push(32'd5, 1'b0); push(32'd6, 1'b0);
        clear = 1'b1; in_data = 32'd100; in_valid = 1'b1;
        #2;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL clear_ready_reported got %b exp 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        check_cnt++; if (out_sum !== 32'd0 || out_valid !== 1'b0) $display("FAIL clear_accum got sum=%h v=%b exp sum=0 v=0", out_sum, out_valid); else pass_cnt++;
        push(32'd1, 1'b0); push(32'd2, 1'b0); push(32'd3, 1'b0);
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL clear_cnt_reset got %b exp 0", out_valid); else pass_cnt++;
        push(32'd4, 1'b0);
        check_cnt++; if (out_valid !== 1'b1 || out_sum !== 32'd10) $display("FAIL clear_sum got v=%b sum=%h exp v=1 sum=a", out_valid, out_sum); else pass_cnt++;
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        check_cnt++; if (out_valid !== 1'b0 || out_sum !== 32'd0 || in_ready !== 1'b1) $display("FAIL clear_hold got v=%b sum=%h rdy=%b exp 0 0 1", out_valid, out_sum, in_ready); else pass_cnt++;
    endtask

    task automatic test_rst();
        push(32'd7, 1'b0); push(32'd7, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_cnt++; if (out_sum !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_mid got sum=%h v=%b rdy=%b exp 0 0 1", out_sum, out_valid, in_ready); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        push(32'd1, 1'b0); push(32'd1, 1'b0); push(32'd1, 1'b0); push(32'hFFFF_FFFF, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_cnt++; if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_cout !== 1'b0) $display("FAIL rst_hold got v=%b sum=%h cout=%b exp 0 0 0", out_valid, out_sum, out_cout); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        push(32'd5, 1'b0); push(32'd5, 1'b0); push(32'd5, 1'b0); push(32'd5, 1'b0);
        check_cnt++; if (out_valid !== 1'b1 || out_sum !== 32'd20) $display("FAIL rst_next_burst got v=%b sum=%h exp v=1 sum=14", out_valid, out_sum); else pass_cnt++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pos_ovf();
        test_sub_ovf();
        test_both_flags();
        test_cout();
        test_hold_stall();
        test_clear();
        test_rst();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
